// File: rtl/cpu_icache_pkg.sv
// cpu_icache_pkg: FSM state encoding and default geometry for the instruction cache controller.
package cpu_icache_pkg;
  typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESPOND} state_t;
  localparam int DEF_LINES = 64;
  localparam int DEF_WORDS_PER_LINE = 4;
  localparam int DEF_ADDR_WIDTH = 32;
endpackage

// File: rtl/icache_ram.sv
// icache_ram: single-write-port RAM with registered read, used for both tag and data storage.
module icache_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end
endmodule

// File: rtl/cpu_icache_ctl.sv
// cpu_icache_ctl: direct-mapped instruction cache controller with word-by-word line fill.
// Define ICACHE_STATS_EN to build the hit/miss counters; otherwise they read as constant 0.
module cpu_icache_ctl
  import cpu_icache_pkg::*;
#(
  parameter int LINES          = DEF_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpui_request,
  input  logic [ADDR_WIDTH-1:0] cpui_addr,
  output logic [31:0]           cpui_rdata,
  output logic                  cpui_ack,
  output logic                  mem_request,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack,
  input  logic                  cache_invalidate,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses
);
  localparam int OW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(LINES);
  localparam int TW = ADDR_WIDTH - IW - OW - 2;

  state_t state, next_state;
  logic [LINES-1:0] valid;
  logic [TW-1:0] in_tag, req_tag, tag_q;
  logic [IW-1:0] in_idx, req_idx;
  logic [OW-1:0] in_off, req_off, fill_cnt, next_off;
  logic [31:0] word_q, resp_data;
  logic fill_inv, hit, fill_ack, last;
  logic unused_byte_bits;

  assign in_off = cpui_addr[OW+1:2];
  assign in_idx = cpui_addr[OW+IW+1:OW+2];
  assign in_tag = cpui_addr[ADDR_WIDTH-1:OW+IW+2];
  assign unused_byte_bits = ^cpui_addr[1:0];

  // valid is read combinationally here, so an invalidate in this cycle only lands after the lookup
  assign hit      = valid[req_idx] && tag_q == req_tag;
  assign fill_ack = state == FILL && mem_ack;
  assign last     = fill_cnt == OW'(WORDS_PER_LINE - 1);
  assign next_off = state == LOOKUP ? '0 : fill_cnt + OW'(1);

  icache_ram #(.DEPTH(LINES), .WIDTH(TW)) u_tag_ram (
    .clock(clock),
    .we(fill_ack && last),
    .waddr(req_idx),
    .wdata(req_tag),
    .raddr(in_idx),
    .rdata(tag_q)
  );

  icache_ram #(.DEPTH(LINES * WORDS_PER_LINE), .WIDTH(32)) u_data_ram (
    .clock(clock),
    .we(fill_ack),
    .waddr({req_idx, fill_cnt}),
    .wdata(mem_rdata),
    .raddr({in_idx, in_off}),
    .rdata(word_q)
  );

  always_ff @(posedge clock) begin
    state <= reset ? IDLE : next_state;
  end

  always_comb begin
    next_state = state == IDLE   ? (cpui_request ? LOOKUP : IDLE) :
                 state == LOOKUP ? (hit ? IDLE : FILL) :
                 state == FILL   ? (fill_ack && last ? RESPOND : FILL) : IDLE;
  end

  always_comb begin
    cpui_ack    = (state == LOOKUP && hit) || state == RESPOND;
    cpui_rdata  = state == RESPOND ? resp_data : (state == LOOKUP && hit) ? word_q : '0;
    mem_request = (state == LOOKUP && !hit) || (fill_ack && !last);
    mem_addr    = mem_request ? {req_tag, req_idx, next_off, 2'b00} : '0;
  end

  always_ff @(posedge clock) begin
    if (state == IDLE && cpui_request) begin
      req_tag <= in_tag;
      req_idx <= in_idx;
      req_off <= in_off;
    end
    if (fill_ack && fill_cnt == req_off) resp_data <= mem_rdata;
    if (reset) begin
      valid    <= '0;
      fill_cnt <= '0;
      fill_inv <= 1'b0;
    end else begin
      if (state == LOOKUP) begin
        fill_cnt <= '0;
        fill_inv <= 1'b0;
      end else if (fill_ack) fill_cnt <= fill_cnt + OW'(1);
      if (cache_invalidate && state == FILL) fill_inv <= 1'b1;
      if (cache_invalidate) valid <= '0;
      else if (fill_ack && last && !fill_inv) valid[req_idx] <= 1'b1;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == LOOKUP) begin
      if (hit) stat_hits <= stat_hits + 32'd1;
      else stat_misses <= stat_misses + 32'd1;
    end
  end
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif
endmodule

// File: tb/tb_cpu_icache_ctl.sv
// tb_cpu_icache_ctl: directed tests of the instruction cache controller against a 3-cycle-latency memory.
module tb_cpu_icache_ctl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic cpui_request = 1'b0;
  logic [31:0] cpui_addr = '0;
  logic [31:0] cpui_rdata;
  logic cpui_ack;
  logic mem_request;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic mem_ack = 1'b0;
  logic cache_invalidate = 1'b0;
  logic [31:0] stat_hits, stat_misses;

  int n_cmp = 0;
  int n_bad = 0;
  int countdown = 0;
  int req_count = 0;
  int stray_req = 0;
  int stray_done = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] req_log [64];

`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  cpu_icache_ctl dut (
    .clock(clock),
    .reset(reset),
    .cpui_request(cpui_request),
    .cpui_addr(cpui_addr),
    .cpui_rdata(cpui_rdata),
    .cpui_ack(cpui_ack),
    .mem_request(mem_request),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .cache_invalidate(cache_invalidate),
    .stat_hits(stat_hits),
    .stat_misses(stat_misses)
  );

  always #5 clock = ~clock;

  // word n of line 0x100 reads 0xA0+n; other lines get a distinct high part
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [27:0] hi;
    hi = a[31:4] ^ 28'h10;
    return {hi, 4'h0} + 32'hA0 + {30'd0, a[3:2]};
  endfunction

  // memory answers three cycles after the cycle in which a request is seen
  always begin
    @(posedge clock);
    #1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    if (countdown == 1) begin
      mem_ack = 1'b1;
      mem_rdata = mem_word(pend_addr);
    end else if (stray_req != stray_done) begin
      mem_ack = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      stray_done = stray_req;
    end
    if (countdown > 0) countdown--;
    @(negedge clock);
    if (mem_request) begin
      if (req_count < 64) req_log[req_count] = mem_addr;
      req_count++;
      pend_addr = mem_addr;
      countdown = 3;
    end
  end

  task automatic fetch(input logic [31:0] a, input int inv_at, output int lat,
                       output logic [31:0] d, output int nreq, output logic ack2);
    int r0;
    lat = 0;
    d = '0;
    @(negedge clock);
    cpui_request = 1'b1;
    cpui_addr = a;
    r0 = req_count;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      cpui_request = 1'b0;
      cache_invalidate = (i == inv_at);
      if (cpui_ack) begin
        lat = i;
        d = cpui_rdata;
        break;
      end
    end
    @(negedge clock);
    cache_invalidate = 1'b0;
    ack2 = cpui_ack;
    nreq = req_count - r0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++; if (cpui_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", cpui_ack); end
    n_cmp++; if (cpui_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", cpui_rdata); end
    n_cmp++; if (mem_request !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req: got %b want 0", mem_request); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_cmp++; if (stat_hits !== 32'h0) begin n_bad++; $display("FAIL reset_hits: got %0d want 0", stat_hits); end
    n_cmp++; if (stat_misses !== 32'h0) begin n_bad++; $display("FAIL reset_misses: got %0d want 0", stat_misses); end
    reset = 1'b0;
  endtask

  task automatic test_cold_miss;
    int lat, nreq, r0;
    logic [31:0] d;
    logic a2;
    r0 = req_count;
    fetch(32'h100, 0, lat, d, nreq, a2);
    n_cmp++; if (lat !== 14) begin n_bad++; $display("FAIL cold_lat: got %0d want 14", lat); end
    n_cmp++; if (d !== 32'hA0) begin n_bad++; $display("FAIL cold_data: got %h want a0", d); end
    n_cmp++; if (nreq !== 4) begin n_bad++; $display("FAIL cold_nreq: got %0d want 4", nreq); end
    n_cmp++; if (a2 !== 1'b0) begin n_bad++; $display("FAIL cold_ack_pulse: got %b want 0", a2); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (req_log[r0+i] !== 32'h100 + 32'(4 * i)) begin
        n_bad++; $display("FAIL cold_addr%0d: got %h want %h", i, req_log[r0+i], 32'h100 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_hit;
    int lat, nreq;
    logic [31:0] d;
    logic a2;
    fetch(32'h108, 0, lat, d, nreq, a2);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL hit_lat: got %0d want 1", lat); end
    n_cmp++; if (d !== 32'hA2) begin n_bad++; $display("FAIL hit_data: got %h want a2", d); end
    n_cmp++; if (nreq !== 0) begin n_bad++; $display("FAIL hit_nreq: got %0d want 0", nreq); end
    n_cmp++; if (a2 !== 1'b0) begin n_bad++; $display("FAIL hit_ack_pulse: got %b want 0", a2); end
    fetch(32'h10F, 0, lat, d, nreq, a2);
    n_cmp++; if (d !== 32'hA3 || lat !== 1) begin n_bad++; $display("FAIL hit_last_word: got %h/%0d want a3/1", d, lat); end
  endtask

  task automatic test_conflict;
    int lat, nreq;
    logic [31:0] d;
    logic a2;
    fetch(32'h1100, 0, lat, d, nreq, a2);
    n_cmp++; if (nreq !== 4 || lat !== 14) begin n_bad++; $display("FAIL conflict_miss: got %0d/%0d want 4/14", nreq, lat); end
    n_cmp++; if (d !== 32'h10A0) begin n_bad++; $display("FAIL conflict_data: got %h want 10a0", d); end
    fetch(32'h1104, 0, lat, d, nreq, a2);
    n_cmp++; if (d !== 32'h10A1 || lat !== 1) begin n_bad++; $display("FAIL conflict_hit: got %h/%0d want 10a1/1", d, lat); end
    fetch(32'h100, 0, lat, d, nreq, a2);
    n_cmp++; if (nreq !== 4) begin n_bad++; $display("FAIL evicted_miss: got %0d want 4", nreq); end
    n_cmp++; if (d !== 32'hA0) begin n_bad++; $display("FAIL evicted_data: got %h want a0", d); end
  endtask

  task automatic test_invalidate;
    int lat, nreq;
    logic [31:0] d;
    logic a2;
    fetch(32'h200, 5, lat, d, nreq, a2);
    n_cmp++; if (lat !== 14 || d !== 32'h3A0) begin n_bad++; $display("FAIL inv_fill_ack: got %0d/%h want 14/3a0", lat, d); end
    fetch(32'h204, 0, lat, d, nreq, a2);
    n_cmp++; if (nreq !== 4) begin n_bad++; $display("FAIL inv_fill_not_valid: got %0d want 4", nreq); end
    n_cmp++; if (d !== 32'h3A1) begin n_bad++; $display("FAIL inv_refill_data: got %h want 3a1", d); end
    fetch(32'h204, 0, lat, d, nreq, a2);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL inv_refill_hit: got %0d want 1", lat); end
    fetch(32'h208, 1, lat, d, nreq, a2);
    n_cmp++; if (lat !== 1 || d !== 32'h3A2) begin n_bad++; $display("FAIL inv_lookup_hit: got %0d/%h want 1/3a2", lat, d); end
    fetch(32'h208, 0, lat, d, nreq, a2);
    n_cmp++; if (nreq !== 4) begin n_bad++; $display("FAIL inv_lookup_cleared: got %0d want 4", nreq); end
  endtask

  task automatic test_reset_mid_fill;
    int acks = 0, got = 0, r0, lat, nreq;
    bit armed = 1'b0;
    logic [31:0] d;
    logic a2;
    @(negedge clock);
    cpui_request = 1'b1;
    cpui_addr = 32'h300;
    for (int i = 0; i < 60 && !armed; i++) begin
      @(negedge clock);
      cpui_request = 1'b0;
      if (mem_ack) acks++;
      if (acks == 2) begin
        reset = 1'b1;
        armed = 1'b1;
      end
    end
    @(negedge clock);
    reset = 1'b0;
    n_cmp++; if (armed !== 1'b1) begin n_bad++; $display("FAIL rst_fill_second_ack: got %0d acks want 2", acks); end
    r0 = req_count;
    repeat (6) begin @(negedge clock); if (cpui_ack) got++; end
    stray_req++;
    repeat (4) begin @(negedge clock); if (cpui_ack) got++; end
    n_cmp++; if (got !== 0) begin n_bad++; $display("FAIL rst_fill_no_ack: got %0d acks want 0", got); end
    n_cmp++; if (req_count - r0 !== 0) begin n_bad++; $display("FAIL rst_fill_stray_req: got %0d want 0", req_count - r0); end
    fetch(32'h300, 0, lat, d, nreq, a2);
    n_cmp++; if (nreq !== 4 || lat !== 14) begin n_bad++; $display("FAIL rst_fill_refetch: got %0d/%0d want 4/14", nreq, lat); end
    n_cmp++; if (d !== 32'h2A0) begin n_bad++; $display("FAIL rst_fill_data: got %h want 2a0", d); end
  endtask

  task automatic test_stats;
    int lat, nreq;
    logic [31:0] d;
    logic a2;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    n_cmp++; if (stat_hits !== 32'h0 || stat_misses !== 32'h0) begin
      n_bad++; $display("FAIL stats_cleared: got %0d/%0d want 0/0", stat_hits, stat_misses);
    end
    fetch(32'h400, 0, lat, d, nreq, a2);
    fetch(32'h400, 0, lat, d, nreq, a2);
    fetch(32'h404, 0, lat, d, nreq, a2);
    fetch(32'h40C, 0, lat, d, nreq, a2);
    n_cmp++; if (d !== 32'h5A3 || lat !== 1) begin n_bad++; $display("FAIL stats_last_hit: got %h/%0d want 5a3/1", d, lat); end
    n_cmp++; if (stat_misses !== (STATS ? 32'd1 : 32'd0)) begin n_bad++; $display("FAIL stats_misses: got %0d want %0d", stat_misses, STATS ? 1 : 0); end
    n_cmp++; if (stat_hits !== (STATS ? 32'd3 : 32'd0)) begin n_bad++; $display("FAIL stats_hits: got %0d want %0d", stat_hits, STATS ? 3 : 0); end
  endtask

  initial begin
    test_reset;
    test_cold_miss;
    test_hit;
    test_conflict;
    test_invalidate;
    test_reset_mid_fill;
    test_stats;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu_icache_ctl.md
CPU_ICACHE_CTL -- requirements
Module: cpu_icache_ctl

Interface
REQ-001 The block SHALL have parameter LINES, default 64, meaning the number of cache lines (power of 2, at least 2).
REQ-002 The block SHALL have parameter WORDS_PER_LINE, default 4, meaning 32-bit words per line (power of 2, at least 2).
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 32, meaning the byte-address width of the CPU and memory buses.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cpui_request  input  1  CPU fetch request, one-cycle pulse.
REQ-007 cpui_addr  input  ADDR_WIDTH  fetch byte address; bits [1:0] ignored.
REQ-008 cpui_rdata  output  32  fetched instruction; 0 whenever cpui_ack is low.
REQ-009 cpui_ack  output  1  one-cycle pulse; fetch complete.
REQ-010 mem_request  output  1  one-cycle pulse; word read request to backing memory.
REQ-011 mem_addr  output  ADDR_WIDTH  word-aligned byte address of the memory read.
REQ-012 mem_rdata  input  32  memory read data, valid with mem_ack.
REQ-013 mem_ack  input  1  one-cycle pulse; memory read complete.
REQ-014 cache_invalidate  input  1  one-cycle pulse; invalidate all lines.
REQ-015 stat_hits, stat_misses  output  32 each  hit/miss counters (see Configuration).

Function
REQ-016 Address split SHALL be: word offset = addr[log2(WORDS_PER_LINE)+1:2]; index = next log2(LINES) bits; tag = remaining upper bits.
REQ-017 Storage SHALL be direct-mapped: per line one valid bit, one tag, WORDS_PER_LINE data words.
REQ-018 FSM states SHALL be IDLE, LOOKUP, FILL, RESPOND.
REQ-019 IDLE + cpui_request: capture address, issue tag/data RAM reads, go LOOKUP; requests in any other state SHALL be ignored.
REQ-020 LOOKUP hit (valid and tag equal): cpui_ack=1 with the stored word this cycle (latency 1 cycle from request), go IDLE.
REQ-021 LOOKUP miss: go FILL; issue mem_request for the line base address (offset 0) in the same cycle.
REQ-022 FILL: on each mem_ack write mem_rdata into the line at the current offset; if more words remain, pulse mem_request for offset+1 in the same cycle; exactly one memory request SHALL be outstanding at a time.
REQ-023 On the mem_ack for the last word: write tag, set valid, go RESPOND.
REQ-024 RESPOND: cpui_ack=1 with the requested word (captured during fill), go IDLE; miss latency = 2 + sum of memory round trips.
REQ-025 cache_invalidate SHALL clear all valid bits in one cycle, in any state.
REQ-026 Invalidate during FILL: the fill SHALL complete and respond normally, but the line SHALL NOT be marked valid.
REQ-027 Invalidate in the same cycle as a LOOKUP: the lookup result SHALL use pre-invalidate state.
REQ-028 mem_ack outside FILL SHALL be ignored.

Reset
REQ-029 Reset SHALL clear all valid bits, set FSM to IDLE, drive cpui_ack, cpui_rdata, mem_request, mem_addr to 0, and clear counters.
REQ-030 Reset mid-fill SHALL abandon the fill with no ack; a later stray mem_ack SHALL be ignored.
REQ-031 Tag and data RAM contents SHALL NOT require reset.

Configuration
REQ-032 Macro ICACHE_STATS_EN defined: stat_hits increments on each LOOKUP hit, stat_misses on each LOOKUP miss, both wrapping modulo 2^32.
REQ-033 Macro ICACHE_STATS_EN undefined: stat_hits and stat_misses SHALL be constant 0 and no counter logic synthesised.

Structure
REQ-034 Package cpu_icache_pkg SHALL hold the FSM state enum and the default values of LINES, WORDS_PER_LINE and ADDR_WIDTH.
REQ-035 Sub-module icache_ram SHALL implement one synchronous-read, single-write-port RAM, instantiated once for tags and once for data.

Verification
REQ-036 Cold fetch of 0x100 (LINES=64, WPL=4), memory returns 0xA0+n per word with a 3-cycle ack delay -> 4 mem_requests at 0x100, 0x104, 0x108, 0x10C, then cpui_ack with 0xA0.
REQ-037 Fetch 0x108 after that fill -> cpui_ack 1 cycle after the request, rdata 0xA2, no mem_request.
REQ-038 Fetch 0x1100 (same index, different tag) -> miss, refill; a following fetch of 0x100 -> miss again.
REQ-039 cache_invalidate during the fill of 0x200 -> ack delivered; the next fetch of 0x200 misses.
REQ-040 Reset asserted on the second mem_ack of a fill -> no cpui_ack; a stray mem_ack is ignored; a fetch of the same address misses.
REQ-041 With ICACHE_STATS_EN, 1 miss then 3 hits -> stat_misses=1, stat_hits=3; without the macro -> both 0.
